// File: rtl/ckpt_pkg.sv
// Shared definitions for the branch checkpoint controller: default sizes,
// checkpoint id width and the controller state encoding.
package ckpt_pkg;

  localparam int DEFAULT_NUM_CKPT  = 4;
  localparam int DEFAULT_ROB_WIDTH = 4;
  localparam int CKPT_ID_W         = $clog2(DEFAULT_NUM_CKPT);
  localparam int PERF_W            = 16;

  // Controller states, kept as plain constants for older tools downstream.
  typedef logic [1:0] state_t;
  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_RECOVER  = 2'd1;
  localparam state_t ST_REDIRECT = 2'd2;

endpackage

// File: rtl/ckpt_age_mask.sv
// Combinational helper: marks every queue slot that is strictly younger than
// slot k, i.e. lies after k and before tail in allocation order.
module ckpt_age_mask
  import ckpt_pkg::*;
#(
  parameter  int NUM_CKPT = DEFAULT_NUM_CKPT,
  localparam int ID_W     = $clog2(NUM_CKPT)
) (
  input  logic [ID_W:0]     head,
  input  logic [ID_W:0]     tail,
  input  logic [ID_W-1:0]   k,
  output logic [NUM_CKPT-1:0] younger
);

  logic [ID_W:0]   occ;
  logic [ID_W-1:0] off_k;
  logic [ID_W-1:0] off_p;

  // Compare each slot's distance from head against k's distance and the occupancy.
  always_comb begin
    occ     = tail - head;
    off_k   = k - head[ID_W-1:0];
    off_p   = '0;
    younger = '0;
    for (int p = 0; p < NUM_CKPT; p++) begin
      off_p      = ID_W'(p) - head[ID_W-1:0];
      younger[p] = (off_p > off_k) && ({1'b0, off_p} < occ);
    end
  end

endmodule

// File: rtl/ckpt_ctrl.sv
// Branch checkpoint controller: allocates map-table snapshots for dispatched
// branches in a circular queue, retires them on correct resolution and runs a
// RECOVER/REDIRECT sequence on a mispredict.
// Optional feature macro: CKPT_PERF_CNT_EN enables the two saturating
// performance counters; without it the counter ports read as zero.
module ckpt_ctrl
  import ckpt_pkg::*;
#(
  parameter  int NUM_CKPT  = DEFAULT_NUM_CKPT,
  parameter  int ROB_WIDTH = DEFAULT_ROB_WIDTH,
  localparam int ID_W      = $clog2(NUM_CKPT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 disp_valid,
  input  logic                 disp_is_branch,
  input  logic [ROB_WIDTH-1:0] disp_rob_tag,
  output logic                 disp_stall,
  output logic                 snap_valid,
  output logic [ROB_WIDTH-1:0] snap_tag,
  output logic [NUM_CKPT-1:0]  branch_mask,
  input  logic                 res_valid,
  input  logic [ID_W-1:0]      res_id,
  input  logic                 res_mispredict,
  output logic [ID_W-1:0]      disp_ckpt_id,
  output logic                 recover_valid,
  output logic [ROB_WIDTH-1:0] recover_tag,
  output logic [NUM_CKPT-1:0]  squash_mask,
  output logic [ID_W:0]        ckpt_count,
  output logic [PERF_W-1:0]    perf_full_stall,
  output logic [PERF_W-1:0]    perf_recoveries
);

  localparam logic [ID_W:0] PTR_ONE = (ID_W+1)'(1);

  state_t               state;
  state_t               state_n;
  logic [ID_W:0]        head;
  logic [ID_W:0]        tail;
  logic [ID_W:0]        head_n;
  logic [ID_W:0]        tail_n;
  logic [NUM_CKPT-1:0]  valid;
  logic [NUM_CKPT-1:0]  valid_n;
  logic [NUM_CKPT-1:0]  younger;
  logic [NUM_CKPT-1:0]  kill;
  logic [ROB_WIDTH-1:0] tags [NUM_CKPT];
  logic [NUM_CKPT-1:0]  squash_q;
  logic [ROB_WIDTH-1:0] rtag_q;
  logic                 full;
  logic                 alloc;
  logic                 mispredict;
  logic                 correct;

  // Occupancy comes straight from the pointers so a full queue can never be
  // overwritten, even when a middle entry has already resolved.
  assign full       = (head[ID_W-1:0] == tail[ID_W-1:0]) && (head[ID_W] != tail[ID_W]);
  assign ckpt_count = tail - head;

  assign disp_stall = (state != ST_RUN) || (full && disp_is_branch) ||
                      (res_valid && res_mispredict);
  assign alloc      = disp_valid && disp_is_branch && !disp_stall;

  assign snap_valid   = alloc;
  assign snap_tag     = disp_rob_tag;
  assign disp_ckpt_id = tail[ID_W-1:0];
  assign branch_mask  = valid;

  assign mispredict = res_valid && res_mispredict && valid[res_id];
  assign correct    = res_valid && !res_mispredict && valid[res_id];
  assign kill       = younger | (NUM_CKPT'(1) << res_id);

  assign recover_valid = (state == ST_RECOVER);
  assign recover_tag   = rtag_q;
  assign squash_mask   = squash_q;

  ckpt_age_mask #(.NUM_CKPT(NUM_CKPT)) u_age_mask (
    .head    (head),
    .tail    (tail),
    .k       (res_id),
    .younger (younger)
  );

  // Next queue contents: mispredict truncates at k, otherwise resolve and
  // allocate both apply; head then skips any retired entries up to tail.
  always_comb begin
    valid_n = valid;
    tail_n  = tail;
    head_n  = head;
    if (mispredict) begin
      valid_n = valid & ~kill;
      tail_n  = head + {1'b0, res_id - head[ID_W-1:0]};
    end else begin
      if (correct) begin
        valid_n[res_id] = 1'b0;
      end
      if (alloc) begin
        valid_n[tail[ID_W-1:0]] = 1'b1;
        tail_n                  = tail + PTR_ONE;
      end
    end
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (head_n != tail_n && !valid_n[head_n[ID_W-1:0]]) begin
        head_n = head_n + PTR_ONE;
      end
    end
  end

  // A mispredict always (re)starts recovery; otherwise walk RECOVER -> REDIRECT -> RUN.
  always_comb begin
    state_n = ST_RUN;
    if (mispredict) begin
      state_n = ST_RECOVER;
    end else begin
      case (state)
        ST_RECOVER:  state_n = ST_REDIRECT;
        ST_REDIRECT: state_n = ST_RUN;
        default:     state_n = ST_RUN;
      endcase
    end
  end

  // Register queue state, stored tags and the recovery payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      head     <= '0;
      tail     <= '0;
      valid    <= '0;
      squash_q <= '0;
      rtag_q   <= '0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      state    <= state_n;
      head     <= head_n;
      tail     <= tail_n;
      valid    <= valid_n;
      squash_q <= mispredict ? kill : '0;
      if (mispredict) begin
        rtag_q <= tags[res_id];
      end
      if (alloc) begin
        tags[tail[ID_W-1:0]] <= disp_rob_tag;
      end
    end
  end

`ifdef CKPT_PERF_CNT_EN
  logic              full_only;
  logic [PERF_W-1:0] perf_stall_q;
  logic [PERF_W-1:0] perf_rec_q;

  assign full_only = (state == ST_RUN) && disp_valid && disp_is_branch && full &&
                     !(res_valid && res_mispredict);

  // Saturating counters for full-queue stalls and recovery entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_rec_q   <= '0;
    end else begin
      if (full_only && perf_stall_q != {PERF_W{1'b1}}) begin
        perf_stall_q <= perf_stall_q + PERF_W'(1);
      end
      if (mispredict && perf_rec_q != {PERF_W{1'b1}}) begin
        perf_rec_q <= perf_rec_q + PERF_W'(1);
      end
    end
  end

  assign perf_full_stall = perf_stall_q;
  assign perf_recoveries = perf_rec_q;
`else
  assign perf_full_stall = '0;
  assign perf_recoveries = '0;
`endif

endmodule

// File: tb/tb_ckpt_ctrl.sv
// Self-checking bench for ckpt_ctrl: a directed vector table, hand-written
// recovery sequences and a randomized run against a queue-based model.
module tb_ckpt_ctrl;
  import ckpt_pkg::*;

  localparam int N  = 4;
  localparam int RW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_valid;
  logic          disp_is_branch;
  logic [RW-1:0] disp_rob_tag;
  logic          disp_stall;
  logic          snap_valid;
  logic [RW-1:0] snap_tag;
  logic [N-1:0]  branch_mask;
  logic          res_valid;
  logic [IW-1:0] res_id;
  logic          res_mispredict;
  logic [IW-1:0] disp_ckpt_id;
  logic          recover_valid;
  logic [RW-1:0] recover_tag;
  logic [N-1:0]  squash_mask;
  logic [IW:0]   ckpt_count;
  logic [15:0]   perf_full_stall;
  logic [15:0]   perf_recoveries;

  int tests_run    = 0;
  int tests_failed = 0;

  ckpt_ctrl #(.NUM_CKPT(N), .ROB_WIDTH(RW)) dut (
    .clk             (clk),
    .reset           (reset),
    .disp_valid      (disp_valid),
    .disp_is_branch  (disp_is_branch),
    .disp_rob_tag    (disp_rob_tag),
    .disp_stall      (disp_stall),
    .snap_valid      (snap_valid),
    .snap_tag        (snap_tag),
    .branch_mask     (branch_mask),
    .res_valid       (res_valid),
    .res_id          (res_id),
    .res_mispredict  (res_mispredict),
    .disp_ckpt_id    (disp_ckpt_id),
    .recover_valid   (recover_valid),
    .recover_tag     (recover_tag),
    .squash_mask     (squash_mask),
    .ckpt_count      (ckpt_count),
    .perf_full_stall (perf_full_stall),
    .perf_recoveries (perf_recoveries)
  );

  always #5 clk = ~clk;

  // Reference model: ordered list of outstanding checkpoints, oldest first.
  typedef struct {
    int id;
    int tag;
    bit v;
  } ent_t;

  ent_t m_queue[$];
  int   m_next;
  int   m_stage;
  int   m_squash;
  int   m_rtag;
  int   m_perf_stall;
  int   m_perf_rec;

  typedef struct {
    bit dv;
    bit ib;
    int tag;
    bit rv;
    int rid;
    bit rm;
    bit stall;
    bit snap;
    int snap_tag;
    int id;
    int count;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit dv, input bit ib, input int tg, input bit rv,
                               input int rid, input bit rm, input bit rs);
    @(negedge clk);
    reset          = rs;
    disp_valid     = dv;
    disp_is_branch = ib;
    disp_rob_tag   = RW'(tg);
    res_valid      = rv;
    res_id         = IW'(rid);
    res_mispredict = rm;
    #1;
  endtask

  function automatic bit model_stall();
    return (m_stage != 0) || (m_queue.size() == N && disp_is_branch) ||
           (res_valid && res_mispredict);
  endfunction

  task automatic modelCheck();
    int bm;
    bit exp_stall;
    bit exp_snap;
    if (reset) return;
    bm = 0;
    foreach (m_queue[i]) if (m_queue[i].v) bm |= (1 << m_queue[i].id);
    exp_stall = model_stall();
    exp_snap  = disp_valid && disp_is_branch && !exp_stall;
    checkOutput("m disp_stall", disp_stall, exp_stall);
    checkOutput("m snap_valid", snap_valid, exp_snap);
    if (exp_snap) checkOutput("m snap_tag", snap_tag, disp_rob_tag);
    checkOutput("m disp_ckpt_id", disp_ckpt_id, m_next);
    checkOutput("m branch_mask", branch_mask, bm);
    checkOutput("m ckpt_count", ckpt_count, m_queue.size());
    checkOutput("m recover_valid", recover_valid, (m_stage == 1));
    checkOutput("m squash_mask", squash_mask, (m_stage == 1) ? m_squash : 0);
    if (m_stage == 1) checkOutput("m recover_tag", recover_tag, m_rtag);
`ifdef CKPT_PERF_CNT_EN
    checkOutput("m perf_full_stall", perf_full_stall, m_perf_stall);
    checkOutput("m perf_recoveries", perf_recoveries, m_perf_rec);
`else
    checkOutput("m perf_full_stall", perf_full_stall, 0);
    checkOutput("m perf_recoveries", perf_recoveries, 0);
`endif
  endtask

  task automatic modelStep();
    int  pos;
    int  sz;
    bit  exp_snap;
    ent_t e;
    if (reset) begin
      m_queue.delete();
      m_next = 0; m_stage = 0; m_squash = 0; m_rtag = 0;
      m_perf_stall = 0; m_perf_rec = 0;
      return;
    end
    sz       = m_queue.size();
    exp_snap = disp_valid && disp_is_branch && !model_stall();
    pos      = -1;
    foreach (m_queue[i]) if (res_valid && m_queue[i].v && m_queue[i].id == int'(res_id)) pos = i;
    if (m_stage == 0 && disp_valid && disp_is_branch && sz == N && !(res_valid && res_mispredict)
        && m_perf_stall < 65535)
      m_perf_stall++;
    if (res_valid && res_mispredict && pos >= 0) begin
      m_squash = 0;
      for (int i = pos; i < sz; i++) m_squash |= (1 << m_queue[i].id);
      m_rtag = m_queue[pos].tag;
      while (m_queue.size() > pos) void'(m_queue.pop_back());
      m_next  = int'(res_id);
      m_stage = 1;
      if (m_perf_rec < 65535) m_perf_rec++;
    end else begin
      if (res_valid && !res_mispredict && pos >= 0) m_queue[pos].v = 1'b0;
      if (exp_snap) begin
        e.id = m_next; e.tag = int'(disp_rob_tag); e.v = 1'b1;
        m_queue.push_back(e);
        m_next = (m_next + 1) % N;
      end
      m_stage = (m_stage == 1) ? 2 : 0;
    end
    while (m_queue.size() > 0 && !m_queue[0].v) void'(m_queue.pop_front());
  endtask

  task automatic finishCycle();
    modelCheck();
    modelStep();
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    finishCycle();
  endtask

  task automatic dispatch(input int tg);
    applyStimulus(1, 1, tg, 0, 0, 0, 0);
    finishCycle();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    finishCycle();
  endtask

  initial begin
    reset = 1'b1; disp_valid = 1'b0; disp_is_branch = 1'b0; disp_rob_tag = '0;
    res_valid = 1'b0; res_id = '0; res_mispredict = 1'b0;
    m_next = 0; m_stage = 0; m_squash = 0; m_rtag = 0; m_perf_stall = 0; m_perf_rec = 0;

    // Fill, overflow, non-branch bypass, then resolve-while-full and refill.
    vecs[0] = '{1, 1,  3, 0, 0, 0, 0, 1,  3, 0, 0};
    vecs[1] = '{1, 1,  5, 0, 0, 0, 0, 1,  5, 1, 1};
    vecs[2] = '{1, 1,  7, 0, 0, 0, 0, 1,  7, 2, 2};
    vecs[3] = '{1, 1,  9, 0, 0, 0, 0, 1,  9, 3, 3};
    vecs[4] = '{1, 1, 11, 0, 0, 0, 1, 0,  0, 0, 4};
    vecs[5] = '{1, 0, 12, 0, 0, 0, 0, 0,  0, 0, 4};
    vecs[6] = '{1, 1, 13, 1, 0, 0, 1, 0,  0, 0, 4};
    vecs[7] = '{1, 1, 13, 0, 0, 0, 0, 1, 13, 0, 3};
    vecs[8] = '{0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 4};

    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset ckpt_count", ckpt_count, 0);
    checkOutput("reset recover_valid", recover_valid, 0);
    checkOutput("reset squash_mask", squash_mask, 0);
    checkOutput("reset disp_stall", disp_stall, 0);
    finishCycle();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].dv, vecs[i].ib, vecs[i].tag, vecs[i].rv, vecs[i].rid, vecs[i].rm, 0);
      checkOutput($sformatf("vec%0d disp_stall", i), disp_stall, vecs[i].stall);
      checkOutput($sformatf("vec%0d snap_valid", i), snap_valid, vecs[i].snap);
      if (vecs[i].snap) checkOutput($sformatf("vec%0d snap_tag", i), snap_tag, vecs[i].snap_tag);
      checkOutput($sformatf("vec%0d disp_ckpt_id", i), disp_ckpt_id, vecs[i].id);
      checkOutput($sformatf("vec%0d ckpt_count", i), ckpt_count, vecs[i].count);
      finishCycle();
    end

    // Mispredict of id 1 with ids 0-3 valid.
    doReset();
    dispatch(3); dispatch(5); dispatch(7); dispatch(9);
    applyStimulus(0, 0, 0, 1, 1, 1, 0);
    checkOutput("mp1 stall", disp_stall, 1);
    finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("mp1 recover_valid", recover_valid, 1);
    checkOutput("mp1 recover_tag", recover_tag, 5);
    checkOutput("mp1 squash_mask", squash_mask, 4'b1110);
    checkOutput("mp1 ckpt_count", ckpt_count, 1);
    finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("mp1 redirect stall", disp_stall, 1);
    checkOutput("mp1 redirect recover_valid", recover_valid, 0);
    finishCycle();
    applyStimulus(1, 1, 4, 0, 0, 0, 0);
    checkOutput("mp1 run stall", disp_stall, 0);
    checkOutput("mp1 run ckpt_id", disp_ckpt_id, 1);
    checkOutput("mp1 run ckpt_count", ckpt_count, 1);
    finishCycle();

    // Wrapped queue (head 3, tail 1), mispredict id 3.
    doReset();
    dispatch(3); dispatch(5); dispatch(7); dispatch(9);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, i, 0, 0);
      finishCycle();
    end
    applyStimulus(1, 1, 14, 0, 0, 0, 0);
    checkOutput("wrap alloc id", disp_ckpt_id, 0);
    checkOutput("wrap count before", ckpt_count, 1);
    finishCycle();
    applyStimulus(0, 0, 0, 1, 3, 1, 0);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap squash_mask", squash_mask, 4'b1001);
    checkOutput("wrap recover_tag", recover_tag, 9);
    checkOutput("wrap tail", disp_ckpt_id, 3);
    checkOutput("wrap count", ckpt_count, 0);
    finishCycle();
    idle(); idle();

    // Mispredict id 2, then id 0 during REDIRECT.
    doReset();
    dispatch(3); dispatch(5); dispatch(7); dispatch(9);
    applyStimulus(0, 0, 0, 1, 2, 1, 0);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("nest first tag", recover_tag, 7);
    checkOutput("nest first squash", squash_mask, 4'b1100);
    finishCycle();
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    checkOutput("nest redirect recover_valid", recover_valid, 0);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("nest second recover_valid", recover_valid, 1);
    checkOutput("nest second tag", recover_tag, 3);
    checkOutput("nest second squash", squash_mask, 4'b0011);
`ifdef CKPT_PERF_CNT_EN
    checkOutput("nest perf_recoveries", perf_recoveries, 2);
`else
    checkOutput("nest perf_recoveries", perf_recoveries, 0);
`endif
    finishCycle();
    idle(); idle();

    // Reset arriving while in RECOVER.
    doReset();
    dispatch(3); dispatch(5);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("rst-rec in RECOVER", recover_valid, 1);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst-rec recover_valid", recover_valid, 0);
    checkOutput("rst-rec squash_mask", squash_mask, 0);
    checkOutput("rst-rec ckpt_count", ckpt_count, 0);
    checkOutput("rst-rec branch_mask", branch_mask, 0);
    checkOutput("rst-rec disp_stall", disp_stall, 0);
    checkOutput("rst-rec recover_tag", recover_tag, 0);
    checkOutput("rst-rec perf_recoveries", perf_recoveries, 0);
    finishCycle();

    // Randomized traffic against the model, with occasional resets.
    doReset();
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(($urandom % 4) != 0, $urandom % 2, $urandom_range(0, 15),
                    ($urandom % 3) == 0, $urandom_range(0, N - 1), ($urandom % 4) == 0,
                    ($urandom % 97) == 0);
      finishCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
